// File: rtl/sat_clamp_pkg.sv
// sat_clamp_pkg: shared types, default sizes and reset-limit helpers for sat_clamp_pipe.
package sat_clamp_pkg;
    localparam int W_DEF     = 32;
    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 16;

    typedef logic signed [W_DEF-1:0] sample_t;

    typedef struct packed {
        sample_t max;
        sample_t min;
    } lim_t;

    typedef struct packed {
        logic hi;
        logic lo;
    } flags_t;

    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/sat_clamp_pipe_lane.sv
// clamp_lane: one channel of the clamp; stage 1 captures sample and compare flags, stage 2 selects and registers.
module clamp_lane
    import sat_clamp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s1_en,
    input  logic         s2_en,
    input  logic [W-1:0] din,
    input  logic [W-1:0] lmax,
    input  logic [W-1:0] lmin,
    input  logic [W-1:0] hold_max,
    input  logic [W-1:0] hold_min,
    output logic [W-1:0] dout,
    output flags_t       flg
);
    logic [W-1:0] ch_q, ch_d, out_q, out_d;
    flags_t       f1_q, f1_d, f2_q, f2_d;

    // hold_max/hold_min are the limits snapshotted when this beat was accepted
    always_comb begin
        ch_d  = s1_en ? din : ch_q;
        f1_d  = s1_en ? flags_t'{hi: $signed(din) > $signed(lmax), lo: $signed(din) < $signed(lmin)} : f1_q;
        out_d = s2_en ? (f1_q.hi ? hold_max : f1_q.lo ? hold_min : ch_q) : out_q;
        f2_d  = s2_en ? f1_q : f2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q  <= '0;
            f1_q  <= '0;
            out_q <= '0;
            f2_q  <= '0;
        end else begin
            ch_q  <= ch_d;
            f1_q  <= f1_d;
            out_q <= out_d;
            f2_q  <= f2_d;
        end
    end

    assign dout = out_q;
    assign flg  = f2_q;
endmodule

// File: rtl/sat_clamp_pipe.sv
// sat_clamp_pipe: N_CH-channel signed saturating clamp in a 2-stage valid/ready pipeline.
// Define SAT_CNT_EN to add per-channel saturating event counters (cnt_clr/sat_cnt ports).
module sat_clamp_pipe
    import sat_clamp_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int N_CH = N_CH_DEF
`ifdef SAT_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic                lim_load,
    input  logic [W-1:0]        lim_max,
    input  logic [W-1:0]        lim_min,
    output logic                cfg_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_CH*W-1:0]   out_data,
`ifdef SAT_CNT_EN
    input  logic                cnt_clr,
    output logic [N_CH*CNT_W-1:0] sat_cnt,
`endif
    output logic [N_CH-1:0]     out_hi,
    output logic [N_CH-1:0]     out_lo
);
    localparam logic [W-1:0] MAX_R = W'(smax(W));
    localparam logic [W-1:0] MIN_R = W'(smin(W));

    logic         s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic         s1_adv, s2_adv, acc, s2_ld, lim_ok;
    logic         cfg_err_q, cfg_err_d;
    logic [W-1:0] lmax_q, lmax_d, lmin_q, lmin_d;
    logic [W-1:0] hmax_q, hmax_d, hmin_q, hmin_d;
    flags_t       flg [N_CH];

    always_comb begin
        s2_adv    = !s2_v_q || out_ready;
        s1_adv    = !s1_v_q || s2_adv;
        acc       = in_valid && s1_adv;
        s2_ld     = s2_adv && s1_v_q;
        s1_v_d    = s1_adv ? in_valid : s1_v_q;
        s2_v_d    = s2_adv ? s1_v_q : s2_v_q;
        lim_ok    = $signed(lim_min) <= $signed(lim_max);
        lmax_d    = (lim_load && lim_ok) ? lim_max : lmax_q;
        lmin_d    = (lim_load && lim_ok) ? lim_min : lmin_q;
        cfg_err_d = lim_load ? !lim_ok : cfg_err_q;
        hmax_d    = acc ? lmax_q : hmax_q;
        hmin_d    = acc ? lmin_q : hmin_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            lmax_q    <= MAX_R;
            lmin_q    <= MIN_R;
            hmax_q    <= MAX_R;
            hmin_q    <= MIN_R;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            cfg_err_q <= cfg_err_d;
            lmax_q    <= lmax_d;
            lmin_q    <= lmin_d;
            hmax_q    <= hmax_d;
            hmin_q    <= hmin_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_v_q;
    assign cfg_err   = cfg_err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        clamp_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en    (acc),
            .s2_en    (s2_ld),
            .din      (in_data[k*W +: W]),
            .lmax     (lmax_q),
            .lmin     (lmin_q),
            .hold_max (hmax_q),
            .hold_min (hmin_q),
            .dout     (out_data[k*W +: W]),
            .flg      (flg[k])
        );
        assign out_hi[k] = flg[k].hi;
        assign out_lo[k] = flg[k].lo;
    end

`ifdef SAT_CNT_EN
    logic [N_CH*CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    // clear wins over increment; counters stick at all-ones
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            if (cnt_clr)
                sat_cnt_d[k*CNT_W +: CNT_W] = '0;
            else if (out_valid && out_ready && (out_hi[k] || out_lo[k]) && !(&sat_cnt_q[k*CNT_W +: CNT_W]))
                sat_cnt_d[k*CNT_W +: CNT_W] = sat_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else     sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif
endmodule
